// File: rtl/alu_serial_pkg.sv
// Shared definitions for the bit-serial ALU: operation encodings and the
// sequencer state type.
package alu_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

endpackage

// File: rtl/alu_serial_bit.sv
// One-bit ALU slice: AND, OR or full add. SUB shares the adder path; the
// controller inverts B and presets the carry for it.
module alu_serial_bit
  import alu_serial_pkg::*;
(
  input  logic [1:0] sel_i,
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_i,
  output logic       s_o,
  output logic       c_o
);

  // Select the slice function; logic ops never produce a carry.
  always_comb begin
    s_o = 1'b0;
    c_o = 1'b0;
    case (sel_i)
      OP_AND:  s_o = a_i & b_i;
      OP_OR:   s_o = a_i | b_i;
      default: begin
        s_o = a_i ^ b_i ^ c_i;
        c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
      end
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer. Processes one bit per cycle, LSB first, through
// a single alu_serial_bit slice.
// Optional feature: define ALU_SERIAL_OVF_EN to add the signed-overflow
// output ovf.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for start; operands latched on the accepting edge
// ST_RUN  | one slice evaluation per cycle, WIDTH cycles
// ST_DONE | result/cout valid, done pulsed for this single cycle
module alu_serial_ctrl
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef ALU_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, sr_q, sr_d;
  logic [WIDTH-1:0] result_q;
  logic             busy_q, done_q, cout_q;
  logic             slice_b, slice_s, slice_c;
`ifdef ALU_SERIAL_OVF_EN
  logic             ovf_q;
`endif

  // Subtraction runs as A + ~B + 1, so B is inverted on its way into the slice.
  always_comb begin
    slice_b = (op_q == OP_SUB) ? ~b_q[0] : b_q[0];
    sr_d    = {slice_s, sr_q[WIDTH-1:1]};
  end

  alu_serial_bit u_bit (
    .sel_i (op_q),
    .a_i   (a_q[0]),
    .b_i   (slice_b),
    .c_i   (carry_q),
    .s_o   (slice_s),
    .c_o   (slice_c)
  );

  // Sequencer with registered outputs; result/cout only change on RUN->DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      op_q     <= OP_AND;
      a_q      <= '0;
      b_q      <= '0;
      sr_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            carry_q <= (op == OP_ADD) ? cin : (op == OP_SUB);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sr_q    <= sr_d;
          carry_q <= slice_c;
          if (cnt_q == CNT_LAST) begin
            cnt_q    <= '0;
            result_q <= sr_d;
            cout_q   <= slice_c;
`ifdef ALU_SERIAL_OVF_EN
            // carry_q here is the carry into the MSB, slice_c the carry out.
            ovf_q    <= op_q[1] & (carry_q ^ slice_c);
`endif
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
`ifdef ALU_SERIAL_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule
